// File: rtl/xor_parity_engine.sv
// XOR parity engine: folds a framed word stream into column parity (XOR word),
// row parity (bit XOR with even/odd mode) and a saturating word count.
module xor_parity_engine #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             mode_odd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic              mode_q;
    logic              accept;

    assign accept = in_valid && in_ready;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE, ACCUM: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_next = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The first word of a frame restarts the fold and is the only place the mode is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            cnt    <= '0;
            mode_q <= 1'b0;
        end else if (accept) begin
            if (state == IDLE) begin
                acc    <= in_data;
                cnt    <= CNT_W'(1);
                mode_q <= mode_odd;
            end else begin
                acc <= acc ^ in_data;
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // Results are only exposed while held; everywhere else the outputs read as zero.
    assign out_word   = (state == HOLD) ? acc : '0;
    assign out_parity = (state == HOLD) ? ((^acc) ^ mode_q) : 1'b0;
    assign out_count  = (state == HOLD) ? cnt : '0;

endmodule

// File: tb/tb_xor_parity_engine.sv
// Self-checking bench for xor_parity_engine: frame-level reference model with a
// per-cycle compare, directed literal vectors, and a CNT_W=4 saturation instance.
module tb_xor_parity_engine;

    localparam int W     = 8;
    localparam int CW    = 16;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          mode_odd;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_word;
    logic          out_parity;
    logic [CW-1:0] out_count;

    logic          s_in_valid;
    logic          s_in_ready;
    logic [W-1:0]  s_in_data;
    logic          s_in_last;
    logic          s_mode_odd;
    logic          s_out_valid;
    logic          s_out_ready;
    logic [W-1:0]  s_out_word;
    logic          s_out_parity;
    logic [3:0]    s_out_count;

    logic          rand_mode;
    logic          rand_bit;
    logic          dir_ready;

    int            checks;
    int            failures;
    int            frames_sent;
    int            results_taken;
    bit            aborted;

    // model state
    bit            pending;
    logic [W-1:0]  frame_q[$];
    logic          frame_mode;
    logic [W-1:0]  exp_word;
    logic          exp_par;
    int            exp_cnt;

    xor_parity_engine #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .mode_odd(mode_odd),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_parity(out_parity), .out_count(out_count)
    );

    xor_parity_engine #(.WIDTH(W), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .in_last(s_in_last), .mode_odd(s_mode_odd),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_word(s_out_word),
        .out_parity(s_out_parity), .out_count(s_out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign out_ready = rand_mode ? rand_bit : dir_ready;

    always @(posedge clk) rand_bit <= 1'($urandom_range(0, 1));

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame result computed from the whole word list: XOR of words, popcount parity, clamped length.
    task automatic closeFrame();
        int ones;
        exp_word = '0;
        ones = 0;
        foreach (frame_q[i]) begin
            exp_word = exp_word ^ frame_q[i];
            ones += $countones(frame_q[i]);
        end
        exp_par = 1'((ones % 2) != 0) ^ frame_mode;
        exp_cnt = (frame_q.size() > CMAX) ? CMAX : frame_q.size();
        frame_q.delete();
        pending = 1'b1;
    endtask

    // Compare first, then predict what the next rising edge will do.
    always @(negedge clk) begin
        if (!rst_n) begin
            pending = 1'b0;
            frame_q.delete();
        end
        checkOutput("cyc_in_ready", 64'(in_ready), 64'(!pending));
        checkOutput("cyc_out_valid", 64'(out_valid), 64'(pending));
        checkOutput("cyc_out_word", 64'(out_word), pending ? 64'(exp_word) : 64'd0);
        checkOutput("cyc_out_parity", 64'(out_parity), pending ? 64'(exp_par) : 64'd0);
        checkOutput("cyc_out_count", 64'(out_count), pending ? 64'(exp_cnt) : 64'd0);
        if (rst_n) begin
            if (!pending && in_valid) begin
                if (frame_q.size() == 0) frame_mode = mode_odd;
                frame_q.push_back(in_data);
                if (in_last) closeFrame();
            end else if (pending && out_ready) begin
                pending = 1'b0;
                results_taken++;
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] d, input logic l, input logic m);
        bit took;
        bit ok;
        ok = 1'b0;
        in_data  = d;
        in_last  = l;
        mode_odd = m;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            if (took) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            aborted = 1'b1;
            $display("[TB] FAIL accept_timeout got=stalled expected=accepted at %0t", $time);
        end else if (l) begin
            frames_sent++;
        end
    endtask

    task automatic takeResult();
        dir_ready = 1'b1;
        @(posedge clk);
        #1;
        dir_ready = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0; frames_sent = 0; results_taken = 0; aborted = 1'b0;
        pending = 1'b0; frame_mode = 1'b0; exp_word = '0; exp_par = 1'b0; exp_cnt = 0;
        rand_mode = 1'b0; dir_ready = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; mode_odd = 1'b0;
        s_in_valid = 1'b0; s_in_data = '0; s_in_last = 1'b0; s_mode_odd = 1'b0; s_out_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_count", 64'(out_count), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single-word frames, even then odd mode
        applyStimulus(8'hA5, 1'b1, 1'b0);
        checkOutput("single_even_valid", 64'(out_valid), 64'd1);
        checkOutput("single_even_word", 64'(out_word), 64'hA5);
        checkOutput("single_even_par", 64'(out_parity), 64'd0);
        checkOutput("single_even_cnt", 64'(out_count), 64'd1);
        takeResult();
        @(posedge clk); #1;
        applyStimulus(8'hA5, 1'b1, 1'b1);
        checkOutput("single_odd_par", 64'(out_parity), 64'd1);
        takeResult();

        // three-word frame; a mode flip on word 2 must not matter
        applyStimulus(8'h01, 1'b0, 1'b0);
        applyStimulus(8'h03, 1'b0, 1'b0);
        applyStimulus(8'h07, 1'b1, 1'b0);
        checkOutput("three_word", 64'(out_word), 64'h05);
        checkOutput("three_par", 64'(out_parity), 64'd0);
        checkOutput("three_cnt", 64'(out_count), 64'd3);
        takeResult();
        applyStimulus(8'h01, 1'b0, 1'b0);
        applyStimulus(8'h03, 1'b0, 1'b1);
        applyStimulus(8'h07, 1'b1, 1'b1);
        checkOutput("modeflip_word", 64'(out_word), 64'h05);
        checkOutput("modeflip_par", 64'(out_parity), 64'd0);

        // backpressure: held result with a waiting input word
        in_data = 8'h55; in_last = 1'b1; mode_odd = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp_word", 64'(out_word), 64'h05);
            checkOutput("bp_cnt", 64'(out_count), 64'd3);
        end
        in_valid = 1'b0;
        takeResult();
        checkOutput("bp_release_ready", 64'(in_ready), 64'd1);
        checkOutput("bp_release_valid", 64'(out_valid), 64'd0);

        // out_ready while idle has no effect
        dir_ready = 1'b1;
        @(posedge clk); #1;
        dir_ready = 1'b0;
        checkOutput("idle_ready_valid", 64'(out_valid), 64'd0);

        // asynchronous reset mid-frame
        applyStimulus(8'h11, 1'b0, 1'b0);
        applyStimulus(8'h22, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_word", 64'(out_word), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(8'hFF, 1'b1, 1'b0);
        checkOutput("postrst_word", 64'(out_word), 64'hFF);
        checkOutput("postrst_cnt", 64'(out_count), 64'd1);
        takeResult();

        // saturation on the narrow counter instance
        s_in_valid = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            s_in_last = (i == 20);
            @(posedge clk); #1;
        end
        s_in_valid = 1'b0; s_in_last = 1'b0;
        checkOutput("sat_valid", 64'(s_out_valid), 64'd1);
        checkOutput("sat_cnt", 64'(s_out_count), 64'd15);
        checkOutput("sat_word", 64'(s_out_word), 64'd0);
        checkOutput("sat_par", 64'(s_out_parity), 64'd0);
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
        checkOutput("sat_release", 64'(s_out_valid), 64'd0);

        // random frames with input gaps and random consumer stalls
        rand_mode = 1'b1;
        for (int f = 0; f < 1000 && !aborted; f++) begin
            int len;
            len = $urandom_range(1, 8);
            for (int k = 0; k < len && !aborted; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                applyStimulus(8'($urandom), k == len - 1, 1'($urandom_range(0, 1)));
            end
        end
        for (int i = 0; i < 200 && pending; i++) begin
            @(posedge clk); #1;
        end
        rand_mode = 1'b0;
        checkOutput("drain_done", 64'(pending), 64'd0);
        checkOutput("frames_vs_results", 64'(results_taken), 64'(frames_sent));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
